// File: rtl/rotary_decoder.sv
// Rotary encoder front end: synchronises and debounces the raw quadrature channels,
// then emits one pulse per detent with direction and a wrap-around position count.
module rotary_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int POS_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rot_a,
    input  logic             rot_b,
    output logic             rotation_event,
    output logic             rotation_left,
    output logic [POS_W-1:0] position
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1_a, r_s2_a, r_deb_a;
    logic             r_s1_b, r_s2_b, r_deb_b;
    logic [CNT_W-1:0] r_cnt_a, r_cnt_b;
    logic             r_q1, r_q1_d, r_q2;
    logic             r_event, r_left;
    logic [POS_W-1:0] r_pos;
    logic             w_q1_rise;

    assign w_q1_rise      = r_q1 & ~r_q1_d;
    assign rotation_event = r_event;
    assign rotation_left  = r_left;
    assign position       = r_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_a  <= 1'b0;
            r_s2_a  <= 1'b0;
            r_deb_a <= 1'b0;
            r_cnt_a <= '0;
            r_s1_b  <= 1'b0;
            r_s2_b  <= 1'b0;
            r_deb_b <= 1'b0;
            r_cnt_b <= '0;
            r_q1    <= 1'b0;
            r_q1_d  <= 1'b0;
            r_q2    <= 1'b0;
            r_event <= 1'b0;
            r_left  <= 1'b0;
            r_pos   <= '0;
        end else begin
            r_s1_a <= rot_a;
            r_s2_a <= r_s1_a;
            r_s1_b <= rot_b;
            r_s2_b <= r_s1_b;

            // Any return to the debounced level restarts the stability count.
            if (r_s2_a != r_deb_a) begin
                if (r_cnt_a == CNT_LAST) begin
                    r_deb_a <= r_s2_a;
                    r_cnt_a <= '0;
                end else begin
                    r_cnt_a <= r_cnt_a + CNT_W'(1);
                end
            end else begin
                r_cnt_a <= '0;
            end

            if (r_s2_b != r_deb_b) begin
                if (r_cnt_b == CNT_LAST) begin
                    r_deb_b <= r_s2_b;
                    r_cnt_b <= '0;
                end else begin
                    r_cnt_b <= r_cnt_b + CNT_W'(1);
                end
            end else begin
                r_cnt_b <= '0;
            end

            // q1 marks the detent (both high), q2 remembers which channel led.
            if (r_deb_a && r_deb_b) begin
                r_q1 <= 1'b1;
            end else if (!r_deb_a && !r_deb_b) begin
                r_q1 <= 1'b0;
            end
            if (!r_deb_a && r_deb_b) begin
                r_q2 <= 1'b1;
            end else if (r_deb_a && !r_deb_b) begin
                r_q2 <= 1'b0;
            end

            r_q1_d  <= r_q1;
            r_event <= w_q1_rise;
            if (w_q1_rise) begin
                r_left <= r_q2;
                r_pos  <= r_q2 ? (r_pos - POS_W'(1)) : (r_pos + POS_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder: reset, single detents, latency, bounce
// rejection, position wrap and reset in the middle of a detent.
module tb_rotary_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rot_a;
    logic       rot_b;
    logic       rotation_event;
    logic       rotation_left;
    logic [7:0] position;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;
    int last_set_cyc = 0;
    int consec = 0;
    logic prev_event = 1'b0;

    rotary_decoder #(
        .DEBOUNCE_CYCLES(16),
        .CNT_W(5),
        .POS_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rot_a(rot_a),
        .rot_b(rot_b),
        .rotation_event(rotation_event),
        .rotation_left(rotation_left),
        .position(position)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rotation_event === 1'b1) begin
            pulse_cnt      = pulse_cnt + 1;
            last_pulse_cyc = cyc;
            if (prev_event === 1'b1) consec = consec + 1;
        end
        prev_event = rotation_event;
    end

    task automatic check(input string tag, input longint observed, input longint expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive a channel pair at a falling edge and hold it for n cycles.
    task automatic apply(input logic a, input logic b, input int n);
        rot_a        = a;
        rot_b        = b;
        last_set_cyc = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic detent_right(input int n);
        apply(1'b1, 1'b0, n);
        apply(1'b1, 1'b1, n);
        apply(1'b0, 1'b0, n);
    endtask

    task automatic detent_left(input int n);
        apply(1'b0, 1'b1, n);
        apply(1'b1, 1'b1, n);
        apply(1'b0, 1'b0, n);
    endtask

    initial begin
        int mark;
        int set11;
        logic deb_seen;

        reset = 1'b1;
        rot_a = 1'b0;
        rot_b = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_event", rotation_event, 0);
        check("reset_left", rotation_left, 0);
        check("reset_pos", position, 0);

        repeat (100) @(negedge clk);
        check("idle_pulses", pulse_cnt, 0);
        check("idle_pos", position, 0);

        // Right detent with latency measurement on the 11 phase.
        apply(1'b1, 1'b0, 40);
        apply(1'b1, 1'b1, 0);
        set11 = last_set_cyc;
        repeat (40) @(negedge clk);
        check("right_pulses", pulse_cnt, 1);
        check("right_latency", last_pulse_cyc - set11, 20);
        check("right_left", rotation_left, 0);
        check("right_pos", position, 1);
        apply(1'b0, 1'b0, 40);
        check("falling_no_event", pulse_cnt, 1);

        detent_left(40);
        check("left_pulses", pulse_cnt, 2);
        check("left_left", rotation_left, 1);
        check("left_pos", position, 0);

        // Bounce on channel A: three-cycle runs never reach the debounce count.
        mark     = pulse_cnt;
        deb_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rot_a = (i % 2 == 0);
            repeat (3) begin
                @(negedge clk);
                deb_seen = deb_seen | dut.r_deb_a;
            end
        end
        rot_a = 1'b0;
        repeat (40) begin
            @(negedge clk);
            deb_seen = deb_seen | dut.r_deb_a;
        end
        check("bounce_deb_a", deb_seen, 0);
        check("bounce_pulses", pulse_cnt - mark, 0);

        // Full wrap of the position counter.
        mark = pulse_cnt;
        for (int i = 0; i < 256; i++) detent_right(25);
        check("wrap_pulses", pulse_cnt - mark, 256);
        check("wrap_pos", position, 0);
        check("wrap_dir", rotation_left, 0);
        detent_left(25);
        check("wrap_left_pos", position, 255);
        check("wrap_left_dir", rotation_left, 1);

        // Reset while the 11 phase is still being debounced.
        mark = pulse_cnt;
        apply(1'b1, 1'b0, 40);
        apply(1'b1, 1'b1, 10);
        reset = 1'b1;
        rot_a = 1'b0;
        rot_b = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_event", rotation_event, 0);
        check("midrst_left", rotation_left, 0);
        check("midrst_pos", position, 0);
        repeat (40) @(negedge clk);
        check("midrst_no_stray", pulse_cnt - mark, 0);
        detent_right(40);
        check("post_rst_pulses", pulse_cnt - mark, 1);
        check("post_rst_pos", position, 1);
        check("post_rst_dir", rotation_left, 0);

        check("no_back_to_back", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
